// File: rtl/rom_sum_sequencer.sv
// Sweeps L ROM words from address 0 (Gray-coded address counter) and sums them through a
// split-carry two-stage adder; reports sum/overflow with a start/busy/done handshake.
module rom_sum_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 200,
    parameter int ROM_LAT  = 1,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);
    localparam int H = ACC_W / 2;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    issued;
    logic [ADDR_W-1:0]  gray_cnt;
    logic [ROM_LAT-1:0] rd_pipe;
    logic               s1_vld;
    logic [DATA_W-1:0]  s1_dat;
    logic               s2_vld;
    logic               s2_carry;
    logic [H-1:0]       s2_hi;
    logic [H-1:0]       acc_lo;
    logic [H-1:0]       acc_hi;
    logic               ovf_acc;
    logic [ACC_W-1:0]   sum_q;
    logic               ovf_q;

    logic [ADDR_W:0]    len_eff;
    logic [ACC_W-1:0]   s1_ext;
    logic [H:0]         lo_add;
    logic [H:0]         hi_add;
    logic [ACC_W-1:0]   pub_sum;
    logic               drained;

    function automatic logic [ADDR_W-1:0] g2b(input logic [ADDR_W-1:0] g);
        logic [ADDR_W-1:0] b;
        b[ADDR_W-1] = g[ADDR_W-1];
        for (int i = ADDR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] gray_next(input logic [ADDR_W-1:0] g);
        logic [ADDR_W-1:0] b;
        b = g2b(g) + 1'b1;
        return b ^ (b >> 1);
    endfunction

    assign len_eff = (len > DEPTH_L) ? DEPTH_L : len;
    assign s1_ext  = ACC_W'(s1_dat);
    assign lo_add  = {1'b0, acc_lo} + {1'b0, s1_ext[H-1:0]};
    assign hi_add  = {1'b0, acc_hi} + {1'b0, s2_hi} + {{H{1'b0}}, s2_carry};
    assign pub_sum = ((SATURATE != 0) && ovf_acc) ? '1 : {acc_hi, acc_lo};
    // Stage 3 completes on the same edge that enters DONE, so only earlier stages must be empty.
    assign drained = !rom_rd && !(|rd_pipe) && !s1_vld;

    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign sum      = (state == S_DONE) ? pub_sum : sum_q;
    assign overflow = (state == S_DONE) ? ovf_acc : ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            issued   <= '0;
            gray_cnt <= '0;
            rd_pipe  <= '0;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            s1_vld   <= 1'b0;
            s1_dat   <= '0;
            s2_vld   <= 1'b0;
            s2_carry <= 1'b0;
            s2_hi    <= '0;
            acc_lo   <= '0;
            acc_hi   <= '0;
            ovf_acc  <= 1'b0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_pipe[0] <= rom_rd;
            for (int i = 1; i < ROM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            s1_vld <= rd_pipe[ROM_LAT-1];
            s1_dat <= rom_data;
            s2_vld <= s1_vld;
            if (s1_vld) begin
                acc_lo   <= lo_add[H-1:0];
                s2_carry <= lo_add[H];
                s2_hi    <= s1_ext[ACC_W-1:H];
            end
            if (s2_vld) begin
                acc_hi  <= hi_add[H-1:0];
                ovf_acc <= ovf_acc | hi_add[H];
            end
            rom_rd <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_lo   <= '0;
                        acc_hi   <= '0;
                        ovf_acc  <= 1'b0;
                        s2_carry <= 1'b0;
                        if (len == '0) begin
                            state <= S_DONE;
                        end else begin
                            // The first read goes out on the accepting edge.
                            len_q    <= len_eff;
                            rom_rd   <= 1'b1;
                            rom_addr <= '0;
                            gray_cnt <= gray_next('0);
                            issued   <= (ADDR_W + 1)'(1);
                            state    <= (len_eff == (ADDR_W + 1)'(1)) ? S_DRAIN : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        rd_pipe <= '0;
                        s1_vld  <= 1'b0;
                        s2_vld  <= 1'b0;
                    end else begin
                        rom_rd   <= 1'b1;
                        rom_addr <= g2b(gray_cnt);
                        gray_cnt <= gray_next(gray_cnt);
                        issued   <= issued + 1'b1;
                        if (issued + 1'b1 == len_q) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        rd_pipe <= '0;
                        s1_vld  <= 1'b0;
                        s2_vld  <= 1'b0;
                    end else if (drained) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    sum_q <= pub_sum;
                    ovf_q <= ovf_acc;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_sum_sequencer.sv
// Directed bench: instance a (ROM_LAT=1, wrap) and instance b (ROM_LAT=3, saturate), each with a ROM model.
module tb_rom_sum_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, abort_a, busy_a, done_a, rd_a, ovf_a;
    logic [8:0]  len_a;
    logic [7:0]  addr_a;
    logic [31:0] data_a, sum_a;
    logic        start_b, abort_b, busy_b, done_b, rd_b, ovf_b;
    logic [8:0]  len_b;
    logic [7:0]  addr_b;
    logic [31:0] data_b, sum_b, pb1, pb2;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) data_a <= mem_a[addr_a];
    always @(posedge clk) begin
        pb1    <= mem_b[addr_b];
        pb2    <= pb1;
        data_b <= pb2;
    end

    rom_sum_sequencer #(.DATA_W(32), .ACC_W(32), .ADDR_W(8), .DEPTH(200), .ROM_LAT(1), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .len(len_a), .abort(abort_a), .busy(busy_a),
        .done(done_a), .rom_rd(rd_a), .rom_addr(addr_a), .rom_data(data_a), .sum(sum_a), .overflow(ovf_a)
    );

    rom_sum_sequencer #(.DATA_W(32), .ACC_W(32), .ADDR_W(8), .DEPTH(200), .ROM_LAT(3), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .len(len_b), .abort(abort_b), .busy(busy_b),
        .done(done_b), .rom_rd(rd_b), .rom_addr(addr_b), .rom_data(data_b), .sum(sum_b), .overflow(ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command and follows it until done (or a 400-cycle budget runs out).
    task automatic run_cmd(input int which, input logic [8:0] l, input bit noise,
                           output int dcyc, output int nrd, output int maxa,
                           output int aerr, output int gerr);
        int t0;
        logic prev_rd, d, r;
        logic [7:0] a, prev_g;
        dcyc = -1; nrd = 0; maxa = -1; aerr = 0; gerr = 0; prev_rd = 1'b0; prev_g = '0;
        if (which == 0) begin start_a = 1'b1; len_a = l; end
        else begin start_b = 1'b1; len_b = l; end
        t0 = cyc;
        for (int i = 1; i <= 400 && dcyc < 0; i++) begin
            tick();
            if (which == 0) begin d = done_a; r = rd_a; a = addr_a; end
            else begin d = done_b; r = rd_b; a = addr_b; end
            start_a = 1'b0;
            start_b = 1'b0;
            if (noise && (i == 1 || i == 3)) begin start_a = 1'b1; len_a = 9'd200; end
            if (r) begin
                if (a != nrd[7:0]) aerr++;
                if (int'(a) > maxa) maxa = int'(a);
                nrd++;
            end
            if (which == 0) begin
                if (r && prev_rd && $countones(dut_a.gray_cnt ^ prev_g) != 1) gerr++;
                prev_g  = dut_a.gray_cnt;
                prev_rd = r;
            end
            if (d) dcyc = cyc - t0;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        int dc, nr, mx, ae, ge;
        bit saw;
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; len_a = '0;
        start_b = 1'b0; abort_b = 1'b0; len_b = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = (i < 200) ? 32'(i) : 32'd1000;
            mem_b[i] = 32'd0;
        end
        repeat (3) tick();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rd", rd_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_sum", sum_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_sum_b", sum_b, 0);
        rst = 1'b0;
        tick();

        // Full sweep: sum 0..199
        run_cmd(0, 9'd200, 1'b0, dc, nr, mx, ae, ge);
        check("sweep_lat", dc, 204);
        check("sweep_reads", nr, 200);
        check("sweep_maxaddr", mx, 199);
        check("sweep_addr_order", ae, 0);
        check("sweep_gray_1bit", ge, 0);
        check("sweep_sum", sum_a, 19900);
        check("sweep_ovf", ovf_a, 0);
        tick();
        check("sweep_done_pulse", done_a, 0);
        check("sweep_sum_held", sum_a, 19900);

        // len beyond DEPTH clamps to 200 reads
        run_cmd(0, 9'd255, 1'b0, dc, nr, mx, ae, ge);
        check("clamp_reads", nr, 200);
        check("clamp_maxaddr", mx, 199);
        check("clamp_lat", dc, 204);
        check("clamp_sum", sum_a, 19900);

        // Abort on the 50th RUN cycle
        tick();
        start_a = 1'b1; len_a = 9'd200;
        tick();
        start_a = 1'b0;
        repeat (49) tick();
        check("abort_busy_before", busy_a, 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_rd", rd_a, 0);
        saw = done_a;
        repeat (20) begin tick(); if (done_a) saw = 1'b1; end
        check("abort_no_done", saw, 0);
        check("abort_sum_kept", sum_a, 19900);
        check("abort_ovf_kept", ovf_a, 0);

        // Restart with rom={1,2,3}; start pulses during busy must be ignored
        mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3;
        run_cmd(0, 9'd3, 1'b1, dc, nr, mx, ae, ge);
        check("restart_lat", dc, 7);
        check("restart_reads", nr, 3);
        check("restart_sum", sum_a, 6);
        tick();
        check("restart_idle_busy", busy_a, 0);

        // Reset in DRAIN
        start_a = 1'b1; len_a = 9'd3;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        check("drain_busy", busy_a, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drainrst_busy", busy_a, 0);
        check("drainrst_rd", rd_a, 0);
        check("drainrst_addr", addr_a, 0);
        check("drainrst_sum", sum_a, 0);
        check("drainrst_ovf", ovf_a, 0);
        saw = done_a;
        repeat (15) begin tick(); if (done_a) saw = 1'b1; end
        check("drainrst_no_done", saw, 0);

        // Overflow, wrapping
        mem_a[0] = 32'hFFFF_FFFF; mem_a[1] = 32'hFFFF_FFFF;
        run_cmd(0, 9'd2, 1'b0, dc, nr, mx, ae, ge);
        check("ovf_wrap_lat", dc, 6);
        check("ovf_wrap_sum", sum_a, 32'hFFFF_FFFE);
        check("ovf_wrap_flag", ovf_a, 1);

        // len=0: immediate done, no reads
        tick();
        run_cmd(0, 9'd0, 1'b0, dc, nr, mx, ae, ge);
        check("len0_lat", dc, 1);
        check("len0_reads", nr, 0);
        check("len0_sum", sum_a, 0);
        check("len0_ovf", ovf_a, 0);

        // Split carry across the low/high halves
        tick();
        mem_a[0] = 32'h0000_FFFF; mem_a[1] = 32'h0000_0001;
        run_cmd(0, 9'd2, 1'b0, dc, nr, mx, ae, ge);
        check("split_a_lat", dc, 6);
        check("split_a_sum", sum_a, 32'h0001_0000);

        mem_b[0] = 32'h0000_FFFF; mem_b[1] = 32'h0000_0001;
        run_cmd(1, 9'd2, 1'b0, dc, nr, mx, ae, ge);
        check("split_b_lat", dc, 8);
        check("split_b_reads", nr, 2);
        check("split_b_sum", sum_b, 32'h0001_0000);
        check("split_b_ovf", ovf_b, 0);

        // Overflow, saturating
        tick();
        mem_b[0] = 32'hFFFF_FFFF; mem_b[1] = 32'hFFFF_FFFF;
        run_cmd(1, 9'd2, 1'b0, dc, nr, mx, ae, ge);
        check("ovf_sat_lat", dc, 8);
        check("ovf_sat_sum", sum_b, 32'hFFFF_FFFF);
        check("ovf_sat_flag", ovf_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_sum_sequencer.md
Name: rom_sum_sequencer

Overview:
- Parametrised successor to the fixed 200-entry ROM summing top.
- On a start command it sweeps a programmable number of ROM words from address 0. Addresses come from a Gray-coded counter, converted to binary at the ROM port.
- Each returned word is accumulated in a split-carry two-stage pipelined adder.
- Reports sum, sticky overflow and a one-cycle done pulse through a start/busy/done handshake. It sits between the per-day solver ROM and the top-level score output.

Parameters:
- DATA_W, 32, width of each ROM word.
- ACC_W, 32, accumulator/sum width. Must be even and >= DATA_W. Split point is ACC_W/2.
- ADDR_W, 8, ROM address width.
- DEPTH, 200, number of valid ROM entries. Must be <= 2^ADDR_W.
- ROM_LAT, 1, cycles from rom_rd/rom_addr to rom_data valid. Range 1..4.
- SATURATE, 0, 1 = clamp sum to all-ones on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  command strobe, sampled in IDLE only
- len  in  ADDR_W+1  number of words to sum, latched on accepted start
- abort  in  1  cancel current run
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle pulse, sum valid
- rom_rd  out  1  read strobe, registered
- rom_addr  out  ADDR_W  binary address, registered
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd
- sum  out  ACC_W  final result, held until next accepted start
- overflow  out  1  sticky carry-out of the current run

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset forces the following: state=IDLE, busy=0, done=0, rom_rd=0, rom_addr=0, sum=0, overflow=0, Gray counter=0, all pipeline valids=0.
- rst mid-run aborts immediately with the same reset values; no done is produced.
- States are IDLE, RUN, DRAIN and DONE.
  - IDLE: start=1 with len>=1 latches L=min(len,DEPTH), clears the accumulator and overflow, sets busy, and moves to RUN. start=1 with len=0 moves to DONE with sum=0; no rom_rd is ever issued.
  - RUN: each cycle asserts rom_rd with rom_addr = gray_to_binary(gray_cnt), then advances gray_cnt to the next Gray code (exactly one bit changes). After issuing L reads (addresses 0..L-1) it moves to DRAIN.
  - DRAIN: waits until the ROM_LAT-deep valid shift register and both adder stages are empty, then moves to DONE.
  - DONE: publishes sum, pulses done for one cycle, clears busy and returns to IDLE.
- start while busy is ignored; len is not re-sampled.
- Pipeline:
  - rom_data is registered with its valid bit (stage 1).
  - Stage 2: acc_lo + data[ACC_W/2-1:0] gives the low half plus a registered carry. Data is zero-extended to ACC_W.
  - Stage 3: acc_hi + data_hi_pipe + carry gives the high half. A carry-out of stage 3 sets overflow.
  - Back-to-back valid words every cycle must be summed exactly (no bubbles required).
- Latency: a start accepted at cycle T gives the first rom_rd at T+1 and done at T+L+ROM_LAT+3.
- Overflow: sticky for the run. With SATURATE=1, once overflow sets, sum reads all-ones at done regardless of later words.
- abort in RUN/DRAIN returns to IDLE next cycle. busy drops, rom_rd drops, in-flight data is discarded, no done is produced, and sum and overflow are left unchanged from the previous completed run. abort in IDLE/DONE is ignored; done still pulses if already in DONE.
- Simultaneous abort and rst: rst wins. Simultaneous abort and start in IDLE: start is accepted.

Test Plan:
- Gray sweep (DATA_W=32, ACC_W=32, ROM_LAT=1): rom[i]=i, start at T with len=200 -> rom_addr steps 0..199 once each, internal Gray changes 1 bit/cycle, done at T+204, sum=19900, overflow=0.
- Split carry: rom[0]=0x0000FFFF, rom[1]=0x00000001, len=2 -> sum=0x00010000. Repeat with ROM_LAT=3 -> same sum, done at T+2+3+3.
- Overflow: rom[0]=rom[1]=0xFFFFFFFF, len=2. SATURATE=0 -> sum=0xFFFFFFFE, overflow=1. SATURATE=1 -> sum=0xFFFFFFFF, overflow=1.
- Boundaries: len=0 -> done at T+1, sum=0, rom_rd never high. len=255 with DEPTH=200 -> exactly 200 reads, rom_addr max=199.
- Abort/restart: previous sum=19900; abort on the 50th RUN cycle -> busy=0 next cycle, no done, sum stays 19900; new start len=3 with rom={1,2,3} -> sum=6.
- Reset/ignored start: start pulses during busy do not change L or timing; rst asserted mid-DRAIN -> all outputs return to reset values next cycle and no done follows.
